// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch state encoding, field widths and address constants
package cpu_pkg;
    typedef enum logic [1:0] {START, REQ, DRAIN, HOLD} fetch_state_t;
    localparam int OPCODE_W = 6;
    localparam int INST_W = 32;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with +4 increment, redirect and pending-target load
import cpu_pkg::*;
module fetch_pc #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_inc,
    input  logic              i_load_tgt,
    input  logic              i_load_pend,
    input  logic              i_pend_we,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pending;
    logic [ADDR_W-1:0] w_target;
    assign w_target = i_target & WORD_ALIGN_MASK[ADDR_W-1:0];
    assign o_pc_plus4 = r_pc + ADDR_W'(4);
    assign o_pc = r_pc;
    // pc advances sequentially or jumps; pending holds the redirect seen while a wrong-path fetch drains
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_pending <= RESET_PC;
        end else begin
            if (i_inc)
                r_pc <= o_pc_plus4;
            else if (i_load_tgt)
                r_pc <= w_target;
            else if (i_load_pend)
                r_pc <= r_pending;
            if (i_pend_we)
                r_pending <= w_target;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with decode handshake and branch redirect
import cpu_pkg::*;
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   inst_pc_plus4,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic [ADDR_W-1:0]   pc
);
    fetch_state_t r_state, w_next;
    logic r_req, r_valid;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc4, w_pc, w_pc_plus4;
    logic w_inc, w_load_tgt, w_load_pend, w_pend_we, w_capture;

    fetch_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clock(clock),
        .reset_n(reset_n),
        .i_inc(w_inc),
        .i_load_tgt(w_load_tgt),
        .i_load_pend(w_load_pend),
        .i_pend_we(w_pend_we),
        .i_target(redirect_target),
        .o_pc(w_pc),
        .o_pc_plus4(w_pc_plus4)
    );

    assign w_capture = (r_state == REQ) && imem_ack && !redirect;
    assign imem_req = r_req;
    assign imem_addr = w_pc;
    assign pc = w_pc;
    assign inst_valid = r_valid;
    assign inst = r_inst;
    assign opcode = r_inst[INST_W-1 -: OPCODE_W];
    assign inst_pc_plus4 = r_pc4;

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= START;
        else
            r_state <= w_next;
    end

    // next state and pc control; acks outside REQ/DRAIN are ignored
    always_comb begin
        w_next = r_state;
        w_inc = 1'b0;
        w_load_tgt = 1'b0;
        w_load_pend = 1'b0;
        w_pend_we = 1'b0;
        case (r_state)
            START: w_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    w_inc = !redirect;
                    w_load_tgt = redirect;
                    w_next = redirect ? REQ : HOLD;
                end else if (redirect) begin
                    w_pend_we = 1'b1;
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_pend_we = redirect;
                if (imem_ack) begin
                    w_load_tgt = redirect;
                    w_load_pend = !redirect;
                    w_next = REQ;
                end
            end
            HOLD: begin
                w_load_tgt = redirect;
                if (redirect || inst_ready)
                    w_next = REQ;
            end
            default: w_next = START;
        endcase
    end

    // registered request flag and instruction buffer presented to decode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req <= 1'b0;
            r_valid <= 1'b0;
            r_inst <= '0;
            r_pc4 <= '0;
        end else begin
            r_req <= (w_next == REQ) || (w_next == DRAIN);
            r_valid <= (w_next == HOLD);
            if (w_capture) begin
                r_inst <= imem_rdata;
                r_pc4 <= w_pc_plus4;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors, corner sequences and randomized check of fetch_unit
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [31:0] inst_pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        rd;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
    } vec_t;
    vec_t tbl[13];

    logic [31:0] exp_pc, prev_inst, prev_addr, row_inst, tgt;
    logic prev_valid, prev_ready, prev_rd, prev_reqpend, armed;
    int lat, delivered;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .opcode(opcode),
        .inst_pc_plus4(inst_pc_plus4),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .pc(pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic a, input logic [31:0] d, input logic r, input logic rd, input logic [31:0] t);
        imem_ack = a;
        imem_rdata = d;
        inst_ready = r;
        redirect = rd;
        redirect_target = t;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0};
        tbl[1]  = '{1'b1, 32'h8C01_0004, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h4, 1'b1, 32'h8C01_0004, 32'h4};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h8C01_0004, 32'h4};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h8C01_0004, 32'h4};
        tbl[5]  = '{1'b1, 32'h2002_0005, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h8C01_0004, 32'h4};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h2002_0005, 32'h8};
        tbl[7]  = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h2002_0005, 32'h8};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h2002_0005, 32'h8};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h2002_0005, 32'h8};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h2002_0005, 32'h8};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h2002_0005, 32'h8};
        tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h2002_0005, 32'h8};

        // directed table: zero-wait fetch, 3-cycle ack, decode backpressure, stray ack
        do_reset();
        chk("reset_pc", pc, 32'h0);
        for (int i = 0; i < 13; i++) begin
            row_inst = tbl[i].inst;
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_inst", i), inst, tbl[i].inst);
            chk($sformatf("tbl%0d_opcode", i), opcode, row_inst[31:26]);
            chk($sformatf("tbl%0d_pc4", i), inst_pc_plus4, tbl[i].pc4);
            set_in(tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].rd, tbl[i].tgt);
            tick();
        end

        // redirect to 0x43 while waiting on memory: drain wrong-path fetch
        do_reset();
        tick();
        chk("drain_req0", imem_req, 1);
        set_in(0, 0, 0, 1, 32'h43);
        tick();
        chk("drain_req1", imem_req, 1);
        chk("drain_addr1", imem_addr, 32'h0);
        set_in(0, 0, 0, 0, 0);
        tick();
        chk("drain_addr2", imem_addr, 32'h0);
        set_in(1, 32'hDEAD_BEEF, 1, 0, 0);
        tick();
        chk("drain_newaddr", imem_addr, 32'h40);
        chk("drain_req3", imem_req, 1);
        chk("drain_novalid", inst_valid, 0);
        chk("drain_noleak", inst, 32'h0);
        set_in(1, 32'h1111_1111, 1, 0, 0);
        tick();
        chk("drain_valid", inst_valid, 1);
        chk("drain_inst", inst, 32'h1111_1111);
        chk("drain_pc4", inst_pc_plus4, 32'h44);

        // redirect together with inst_ready in HOLD
        do_reset();
        tick();
        set_in(1, 32'hAAAA_0001, 1, 0, 0);
        tick();
        chk("hold_valid", inst_valid, 1);
        set_in(0, 0, 1, 1, 32'h100);
        tick();
        chk("hold_drop", inst_valid, 0);
        chk("hold_req", imem_req, 1);
        chk("hold_addr", imem_addr, 32'h100);
        set_in(1, 32'hBBBB_0002, 1, 0, 0);
        tick();
        chk("hold_inst", inst, 32'hBBBB_0002);
        chk("hold_pc4", inst_pc_plus4, 32'h104);

        // two redirects during DRAIN: last one wins
        do_reset();
        tick();
        set_in(0, 0, 1, 1, 32'h200);
        tick();
        chk("dbl_addr1", imem_addr, 32'h0);
        set_in(0, 0, 1, 1, 32'h301);
        tick();
        chk("dbl_addr2", imem_addr, 32'h0);
        set_in(1, 32'hCCCC_CCCC, 1, 0, 0);
        tick();
        chk("dbl_req", imem_req, 1);
        chk("dbl_addr", imem_addr, 32'h300);
        chk("dbl_novalid", inst_valid, 0);

        // fetch at the top of the address space wraps to zero
        do_reset();
        tick();
        set_in(1, 32'h0, 1, 1, 32'hFFFF_FFFF);
        tick();
        chk("wrap_req", imem_req, 1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        set_in(1, 32'hDDDD_0003, 1, 0, 0);
        tick();
        chk("wrap_inst", inst, 32'hDDDD_0003);
        chk("wrap_pc4", inst_pc_plus4, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        set_in(0, 0, 1, 0, 0);
        tick();
        chk("wrap_next", imem_addr, 32'h0);
        chk("wrap_nreq", imem_req, 1);

        // asynchronous reset in the middle of DRAIN
        do_reset();
        tick();
        set_in(0, 0, 1, 1, 32'h80);
        tick();
        chk("mid_req", imem_req, 1);
        set_in(0, 0, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_valid", inst_valid, 0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_pc4", inst_pc_plus4, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk("mid_start", imem_req, 0);
        tick();
        chk("mid_restart_req", imem_req, 1);
        chk("mid_restart_addr", imem_addr, 32'h0);

        // randomized traffic checked against an instruction-stream model
        do_reset();
        exp_pc = 32'h0;
        prev_valid = 0; prev_ready = 0; prev_rd = 0; prev_reqpend = 0; armed = 0;
        prev_inst = 0; prev_addr = 0;
        lat = -1; delivered = 0;
        for (int k = 0; k < 4000; k++) begin
            if (prev_reqpend) begin
                chk("rnd_req_hold", imem_req, 1);
                chk("rnd_addr_hold", imem_addr, prev_addr);
            end
            if (imem_req) chk("rnd_align", {30'b0, imem_addr[1:0]}, 32'h0);
            if (inst_valid && imem_req) chk("rnd_req_in_hold", imem_req, 0);
            if (inst_valid) chk("rnd_opcode", opcode, inst[31:26]);
            if (inst_valid && !prev_valid) begin
                chk("rnd_inst", inst, mem_f(exp_pc));
                chk("rnd_pc4", inst_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (prev_valid && !prev_ready && !prev_rd) begin
                chk("rnd_stall_valid", inst_valid, 1);
                chk("rnd_stall_inst", inst, prev_inst);
            end
            if (imem_req) armed = 1;
            if (imem_req) begin
                if (lat < 0) lat = int'($urandom_range(0, 3));
                if (lat == 0) begin
                    imem_ack = 1;
                    imem_rdata = mem_f(imem_addr);
                    lat = -1;
                end else begin
                    imem_ack = 0;
                    imem_rdata = $urandom;
                    lat--;
                end
            end else begin
                lat = -1;
                imem_ack = ($urandom % 10 == 0);
                imem_rdata = $urandom;
            end
            inst_ready = ($urandom % 4 != 0);
            redirect = armed && ($urandom % 10 == 0);
            tgt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h3FF);
            redirect_target = tgt;
            if (redirect) exp_pc = tgt & 32'hFFFF_FFFC;
            prev_reqpend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            prev_inst = inst;
            prev_valid = inst_valid;
            prev_ready = inst_ready;
            prev_rd = redirect;
            tick();
        end
        chk("rnd_progress", {31'b0, delivered > 100}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
